// File: rtl/mem_stage_hs_pkg.sv
// Shared constants and types for the RV32I memory stage: opcodes, access sizes,
// handshake FSM states and the reset instruction.
package mem_stage_hs_pkg;

  localparam logic [6:0] LCC  = 7'b0000011;
  localparam logic [6:0] SCC  = 7'b0100011;
  localparam logic [6:0] JAL  = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    BYTE     = 2'b00,
    HALFWORD = 2'b01,
    WORD     = 2'b10
  } size_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // funct3[1:0] selects the access size; the unused encoding behaves as a word.
  function automatic size_e decode_size(input logic [2:0] funct3);
    case (funct3[1:0])
      2'b00:   decode_size = BYTE;
      2'b01:   decode_size = HALFWORD;
      default: decode_size = WORD;
    endcase
  endfunction

endpackage

// File: rtl/mem_stage_hs_lane_align.sv
// Byte-lane steering: store byte enables and data replication, load lane
// extraction with sign or zero extension.
module mem_lane_align
  import mem_stage_hs_pkg::*;
(
  input  size_e       size,
  input  logic        is_unsigned,
  input  logic [1:0]  offset,
  input  logic [31:0] store_data,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    be    = 4'hF;
    wdata = store_data;
    case (size)
      BYTE: begin
        be    = 4'b0001 << offset;
        wdata = {4{store_data[7:0]}};
      end
      HALFWORD: begin
        be    = 4'b0011 << {offset[1], 1'b0};
        wdata = {2{store_data[15:0]}};
      end
      default: begin
        be    = 4'hF;
        wdata = store_data;
      end
    endcase
  end

  always_comb begin
    lane_byte = rdata[{offset, 3'b000} +: 8];
    lane_half = rdata[{offset[1], 4'b0000} +: 16];
    case (size)
      BYTE:     load_data = {{24{lane_byte[7] & ~is_unsigned}}, lane_byte};
      HALFWORD: load_data = {{16{lane_half[15] & ~is_unsigned}}, lane_half};
      default:  load_data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_hs.sv
// RV32I memory stage: X/M pipeline register, variable-latency req/ack data
// memory handshake with bounded wait, store lane generation and load extension.
module mem_stage_hs
  import mem_stage_hs_pkg::*;
#(
  parameter int          ADDR_W   = 32,
  parameter int          MAX_WAIT = 16,
  parameter logic [31:0] NOP_INST = NOP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_x,
  input  logic [31:0]       PC_x,
  input  logic [31:0]       alu_x,
  input  logic [31:0]       rs2_x,
  input  logic [31:0]       inst_x,
  input  logic              wm_bypass,
  input  logic [31:0]       wb_w_bypass,
  output logic              stall_m,
  output logic              valid_m,
  output logic [31:0]       inst_m,
  output logic [31:0]       alu_m,
  output logic [31:0]       wb_m,
  output logic              misaligned_m,
  output logic              fault_m,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [31:0]       dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata
);

  localparam int CNT_W = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_WAIT - 1);

  logic        valid_reg;
  logic [31:0] inst_reg, alu_reg, rs2_reg, pc_reg;
  state_e      state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;

  // X/M boundary: holds while the memory access is outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_reg <= 1'b0;
      inst_reg  <= NOP_INST;
      alu_reg   <= '0;
      rs2_reg   <= '0;
      pc_reg    <= '0;
    end else if (!stall_m) begin
      valid_reg <= valid_x;
      inst_reg  <= inst_x;
      alu_reg   <= alu_x;
      rs2_reg   <= rs2_x;
      pc_reg    <= PC_x;
    end
  end

  logic [6:0] opcode;
  logic [2:0] funct3;
  size_e      size;
  logic       is_load, is_store, is_jump, mem_op;

  assign opcode   = inst_reg[6:0];
  assign funct3   = inst_reg[14:12];
  assign size     = decode_size(funct3);
  assign is_load  = valid_reg && (opcode == LCC);
  assign is_store = valid_reg && (opcode == SCC);
  assign is_jump  = (opcode == JAL) || (opcode == JALR);

  assign misaligned_m = (is_load || is_store) &&
                        (((size == HALFWORD) && alu_reg[0]) ||
                         ((size == WORD) && (alu_reg[1:0] != 2'b00)));
  assign mem_op = (is_load || is_store) && !misaligned_m;

  logic complete, timeout, req;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    req        = 1'b0;
    complete   = 1'b0;
    timeout    = 1'b0;
    case (state_reg)
      IDLE: begin
        req = mem_op;
        if (mem_op) begin
          if (dmem_ack) begin
            complete = 1'b1;
          end else begin
            state_next = WAIT;
            cnt_next   = CNT_W'(1);
          end
        end
      end
      WAIT: begin
        req = 1'b1;
        if (dmem_ack) begin
          complete   = 1'b1;
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg == CNT_LAST) begin
          // Give up: retire the access with a fault and withdraw the request.
          timeout    = 1'b1;
          complete   = 1'b1;
          req        = 1'b0;
          state_next = IDLE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  logic [31:0] store_data, load_data;
  assign store_data = wm_bypass ? wb_w_bypass : rs2_reg;

  mem_lane_align u_lane (
    .size        (size),
    .is_unsigned (funct3[2]),
    .offset      (alu_reg[1:0]),
    .store_data  (store_data),
    .rdata       (dmem_rdata),
    .be          (dmem_be),
    .wdata       (dmem_wdata),
    .load_data   (load_data)
  );

  always_comb begin
    wb_m = alu_reg;
    if (!valid_reg)   wb_m = '0;
    else if (is_load) wb_m = (misaligned_m || timeout) ? 32'h0 : load_data;
    else if (is_jump) wb_m = pc_reg + 32'd4;
  end

  assign stall_m   = mem_op && !complete;
  assign fault_m   = timeout;
  assign dmem_req  = req;
  assign dmem_we   = is_store;
  assign dmem_addr = {alu_reg[ADDR_W-1:2], 2'b00};
  assign valid_m   = valid_reg;
  assign inst_m    = inst_reg;
  assign alu_m     = alu_reg;

endmodule

// File: tb/tb_mem_stage_hs.sv
// Scoreboard bench for mem_stage_hs: the driver queues expected results per
// instruction, a negedge monitor compares them when the M stage retires.
module tb_mem_stage_hs;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_x;
  logic [31:0] PC_x, alu_x, rs2_x, inst_x;
  logic        wm_bypass;
  logic [31:0] wb_w_bypass;
  logic        stall_m, valid_m, misaligned_m, fault_m;
  logic [31:0] inst_m, alu_m, wb_m;
  logic        dmem_req, dmem_we, dmem_ack;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;

  always #5 clk = ~clk;

  mem_stage_hs dut (
    .clk(clk), .reset(reset), .valid_x(valid_x), .PC_x(PC_x), .alu_x(alu_x),
    .rs2_x(rs2_x), .inst_x(inst_x), .wm_bypass(wm_bypass), .wb_w_bypass(wb_w_bypass),
    .stall_m(stall_m), .valid_m(valid_m), .inst_m(inst_m), .alu_m(alu_m), .wb_m(wb_m),
    .misaligned_m(misaligned_m), .fault_m(fault_m), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  typedef struct {
    string       name;
    logic [31:0] wb;
    logic        chk_st;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] addr;
    logic        req;
    logic        we;
    logic        mis;
    logic        fault;
    int          stalls;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   stall_cnt = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] req_v);
    n_checks++;
    if (act !== req_v) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", nm, act, req_v);
    end
  endfunction

  // Monitor: retirement is valid_m with no stall on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        stall_cnt = 0;
      end else if (valid_m) begin
        if (stall_m) begin
          stall_cnt++;
        end else if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_retire: got wb %h, expected no instruction", wb_m);
        end else begin
          e = exp_q.pop_front();
          check({e.name, ".wb"},     wb_m, e.wb);
          check({e.name, ".req"},    {31'b0, dmem_req}, {31'b0, e.req});
          check({e.name, ".we"},     {31'b0, dmem_we}, {31'b0, e.we});
          check({e.name, ".mis"},    {31'b0, misaligned_m}, {31'b0, e.mis});
          check({e.name, ".fault"},  {31'b0, fault_m}, {31'b0, e.fault});
          check({e.name, ".addr"},   dmem_addr, e.addr);
          check({e.name, ".stalls"}, stall_cnt, e.stalls);
          if (e.chk_st) begin
            check({e.name, ".be"},    {28'b0, dmem_be}, {28'b0, e.be});
            check({e.name, ".wdata"}, dmem_wdata, e.wdata);
          end
          $display("txn %s: wb=%h be=%b wdata=%h addr=%h stalls=%0d fault=%b",
                   e.name, wb_m, dmem_be, dmem_wdata, dmem_addr, stall_cnt, fault_m);
          stall_cnt = 0;
        end
      end
    end
  end

  function automatic exp_t mk(string nm, logic [31:0] wb, logic chk_st, logic [3:0] be,
                              logic [31:0] wdata, logic [31:0] addr, logic req, logic we,
                              logic mis, logic fault, int stalls);
    exp_t e;
    e.name = nm; e.wb = wb; e.chk_st = chk_st; e.be = be; e.wdata = wdata;
    e.addr = addr; e.req = req; e.we = we; e.mis = mis; e.fault = fault; e.stalls = stalls;
    return e;
  endfunction

  // Issue one instruction, then play the memory: ack arrives `delay` cycles
  // after the instruction reaches M (delay < 0 means never).
  task automatic issue(input logic [31:0] inst, input logic [31:0] pc, input logic [31:0] alu,
                       input logic [31:0] rs2, input logic byp, input logic [31:0] bypd,
                       input int delay, input logic [31:0] rdata, input exp_t e);
    int k;
    @(posedge clk); #1;
    valid_x = 1'b1; inst_x = inst; PC_x = pc; alu_x = alu; rs2_x = rs2;
    wm_bypass = byp; wb_w_bypass = bypd;
    exp_q.push_back(e);
    @(posedge clk); #1;
    valid_x = 1'b0;
    k = 0;
    dmem_ack = (delay == 0);
    dmem_rdata = rdata;
    #1;
    while (!(valid_m && !stall_m) && k < 100) begin
      @(posedge clk); #1;
      k++;
      dmem_ack = (k == delay);
      #1;
    end
    if (k >= 100) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s.timeout_bound: got no retirement in %0d cycles, expected retirement", e.name, k);
    end
    @(posedge clk); #1;
    dmem_ack = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_x = 1'b0; PC_x = '0; alu_x = '0; rs2_x = '0; inst_x = '0;
    wm_bypass = 1'b0; wb_w_bypass = '0; dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("rst.valid_m", {31'b0, valid_m}, 32'h0);
    check("rst.inst_m",  inst_m, 32'h0000_0013);
    check("rst.req",     {31'b0, dmem_req}, 32'h0);
    check("rst.stall",   {31'b0, stall_m}, 32'h0);
    check("rst.wb",      wb_m, 32'h0);

    issue(32'h0000_2023, 32'h0, 32'h100, 32'hDEAD_BEEF, 1'b0, 32'h0, 0, 32'h0,
          mk("sw", 32'h100, 1'b1, 4'hF, 32'hDEAD_BEEF, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    issue(32'h0000_0003, 32'h0, 32'h103, 32'h0, 1'b0, 32'h0, 3, 32'h80FF_FF7F,
          mk("lb", 32'hFFFF_FF80, 1'b0, 4'h0, 32'h0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 3));
    issue(32'h0000_4003, 32'h0, 32'h103, 32'h0, 1'b0, 32'h0, 3, 32'h80FF_FF7F,
          mk("lbu", 32'h0000_0080, 1'b0, 4'h0, 32'h0, 32'h100, 1'b1, 1'b0, 1'b0, 1'b0, 3));
    issue(32'h0000_1023, 32'h0, 32'h202, 32'h0000_1234, 1'b1, 32'hABCD_5678, 0, 32'h0,
          mk("sh_byp", 32'h202, 1'b1, 4'b1100, 32'h5678_5678, 32'h200, 1'b1, 1'b1, 1'b0, 1'b0, 0));
    issue(32'h0000_2003, 32'h0, 32'h101, 32'h0, 1'b0, 32'h0, 0, 32'hFFFF_FFFF,
          mk("lw_mis", 32'h0, 1'b0, 4'h0, 32'h0, 32'h100, 1'b0, 1'b0, 1'b1, 1'b0, 0));
    issue(32'h0000_2003, 32'h0, 32'h200, 32'h0, 1'b0, 32'h0, -1, 32'h1234_5678,
          mk("lw_tmo", 32'h0, 1'b0, 4'h0, 32'h0, 32'h200, 1'b0, 1'b0, 1'b0, 1'b1, 15));

    // Late ack after the timeout must not disturb anything.
    dmem_ack = 1'b1;
    #1;
    check("late_ack.req",   {31'b0, dmem_req}, 32'h0);
    check("late_ack.fault", {31'b0, fault_m}, 32'h0);
    @(posedge clk); #1;
    dmem_ack = 1'b0;

    issue(32'h0000_0013, 32'h0, 32'h55, 32'h0, 1'b0, 32'h0, 0, 32'h0,
          mk("addi", 32'h55, 1'b0, 4'h0, 32'h0, 32'h54, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    issue(32'h0000_1003, 32'h0, 32'h302, 32'h0, 1'b0, 32'h0, 1, 32'h8001_7FFF,
          mk("lh", 32'hFFFF_8001, 1'b0, 4'h0, 32'h0, 32'h300, 1'b1, 1'b0, 1'b0, 1'b0, 1));
    issue(32'h0000_0023, 32'h0, 32'h101, 32'h1234_5678, 1'b0, 32'hFFFF_FFFF, 2, 32'h0,
          mk("sb", 32'h101, 1'b1, 4'b0010, 32'h7878_7878, 32'h100, 1'b1, 1'b1, 1'b0, 1'b0, 2));

    // Reset while waiting on memory.
    @(posedge clk); #1;
    valid_x = 1'b1; inst_x = 32'h0000_2003; alu_x = 32'h200; PC_x = 32'h0;
    @(posedge clk); #1;
    valid_x = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("wait.stall_before_reset", {31'b0, stall_m}, 32'h1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    check("rst_wait.req",     {31'b0, dmem_req}, 32'h0);
    check("rst_wait.valid_m", {31'b0, valid_m}, 32'h0);
    check("rst_wait.inst_m",  inst_m, 32'h0000_0013);

    issue(32'h0000_006F, 32'h40, 32'h0, 32'h0, 1'b0, 32'h0, 0, 32'h0,
          mk("jal", 32'h44, 1'b0, 4'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    issue(32'h0000_2003, 32'h0, 32'h10, 32'h0, 1'b0, 32'h0, 0, 32'hCAFE_F00D,
          mk("lw", 32'hCAFE_F00D, 1'b0, 4'h0, 32'h0, 32'h10, 1'b1, 1'b0, 1'b0, 1'b0, 0));

    repeat (2) @(posedge clk);
    check("scoreboard_drained", exp_q.size(), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_stage_hs.md
Name: mem_stage_hs

Overview:
- Next-generation memory stage of the 5-stage RV32I pipeline.
- Adds a registered X/M pipeline boundary and a req/ack data-memory handshake with variable latency.
- Emits a stall to upstream stages, generates byte lanes for stores, and sign/zero-extends loads.
- Adds misalignment detection and a bounded-wait timeout fault.

Parameters:
- ADDR_W, 32, data-memory address width (alu result is truncated to ADDR_W[ADDR_W-1:0]).
- MAX_WAIT, 16, max cycles spent in WAIT before timeout fault (>=2).
- NOP_INST, 32'h00000013, instruction value loaded into inst_m on reset.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- valid_x  in  1  X-stage instruction valid.
- PC_x  in  32  PC of X-stage instruction.
- alu_x  in  32  ALU result (effective address for loads/stores).
- rs2_x  in  32  store data from X.
- inst_x  in  32  X-stage instruction.
- wm_bypass  in  1  select wb_w_bypass as store data (W->M forward), evaluated in M.
- wb_w_bypass  in  32  W-stage writeback value.
- stall_m  out  1  holds F/D/X and the X/M register.
- valid_m  out  1  M-stage instruction valid.
- inst_m  out  32  registered instruction.
- alu_m  out  32  registered ALU result.
- wb_m  out  32  writeback value (combinational from M state).
- misaligned_m  out  1  misaligned access in M.
- fault_m  out  1  timeout fault, 1-cycle pulse on completion.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address (low 2 bits 0).
- dmem_wdata  out  32  lane-replicated store data.
- dmem_be  out  4  byte enables.
- dmem_ack  in  1  request accepted/completed; dmem_rdata valid same cycle.
- dmem_rdata  in  32  read word.

Behaviour:
- X/M register: at posedge, if reset: valid_m=0, inst_m=NOP_INST, alu_m=0, rs2_m=0, PC_m=0. Else if !stall_m: capture valid_x, inst_x, alu_x, rs2_x, PC_x. Else hold.
- Decode from inst_m: opcode LCC = load, SCC = store; funct3 000/100 byte, 001/101 half, 010 word; 100/101 unsigned.
- misaligned_m = valid_m & mem op & ((half & a[0]) | (word & a[1:0]!=0)). A misaligned op issues no request and does not stall; loads give wb_m=0 and stores are dropped.
- mem_op = valid_m & (load|store) & !misaligned_m.
- FSM states IDLE, WAIT, plus wait counter cnt:
  - IDLE: dmem_req=mem_op. If mem_op & dmem_ack, complete this cycle, stay IDLE. If mem_op & !ack, go WAIT with cnt=1.
  - WAIT: dmem_req=1. On ack, complete and go IDLE. Else if cnt==MAX_WAIT-1, timeout-complete (fault_m=1, req=0 this cycle, load wb_m=0) and go IDLE. Else cnt++.
- stall_m = mem_op & !(completing this cycle). Zero-wait ack therefore gives no stall. Address and data stay stable while req is high because the X/M register holds.
- Store lanes (a = alu_m[1:0]):
  - SB: be=4'b0001<<a, wdata={4{d[7:0]}}.
  - SH: be=4'b0011<<{a[1],1'b0}, wdata={2{d[15:0]}}.
  - SW: be=4'hF, wdata=d.
  - d = wm_bypass ? wb_w_bypass : rs2_m. dmem_we=store.
- Load extraction: select byte/half lane of dmem_rdata by a; sign-extend unless unsigned.
- wb_m priority:
  - load: extracted data (0 on misaligned/timeout).
  - JAL/JALR: PC_m+4.
  - else: alu_m.
  - !valid_m: 0.
- Reset in WAIT: next edge state=IDLE, cnt=0, valid_m=0, so req drops. A late ack after reset/timeout is ignored.
- Only one outstanding request. dmem_ack in IDLE with no req is ignored.

Decomposition:
- Shared package: opcode constants (LCC, SCC, JAL, JALR), access-size encodings (BYTE, HALFWORD, WORD), FSM state enum, NOP constant.
- One sub-module: mem_lane_align, combinational, covering store byte-enable/replication and load extract/extend. It is reused by a future I-side/atomic path.

Test Plan:
- SW x=0xDEADBEEF to 0x100, ack same cycle -> be=F, addr=0x100, wdata=DEADBEEF, stall_m never high.
- LB from 0x103, rdata=0x80FF_FF7F, ack after 3 cycles -> stall_m high 3 cycles, wb_m=0xFFFFFF80. LBU gives 0x00000080.
- SH 0x1234 to 0x202 with wm_bypass=1, wb_w_bypass=0xABCD5678 -> be=4'b1100, wdata=0x56785678.
- LW from 0x101 -> misaligned_m=1, dmem_req=0, no stall, wb_m=0.
- LW with no ack -> stall for MAX_WAIT-1 cycles, fault_m pulse, wb_m=0, then next instruction proceeds. A late ack is ignored.
- Reset asserted in WAIT -> dmem_req=0 next cycle, valid_m=0, inst_m=0x00000013. JAL at PC 0x40 after reset -> wb_m=0x44.
